// File: rtl/seq_adder.sv
// ---------------------------------------------------------------------------
// seq_adder
//   Bit-serial unsigned adder. On start it captures a, b and cin, then adds
//   one bit per clock LSB-first. After WIDTH SHIFT cycles it loads sum/carry
//   and pulses done for one cycle. Results hold until the next completion.
//
// Parameters
//   WIDTH  operand width in bits (1..64)
//
// Ports
//   clk    single clock, rising edge
//   rst    synchronous active-high reset (priority over start)
//   start  begin an addition; accepted in IDLE or DONE, ignored while busy
//   a, b   unsigned operands, sampled only when start is accepted
//   cin    carry-in, sampled with the operands
//   busy   high exactly while the SHIFT state is active
//   done   one-cycle pulse in the DONE state; sum/carry valid from then on
//   sum    registered result sum
//   carry  registered result carry-out
//   ovf    (only with SEQ_ADDER_OVF_EN) signed overflow of the last addition
//
// Handshake: start is a single-cycle request with no ready signal; it is
//   taken on any rising edge where the FSM is in IDLE or DONE and rst is low.
//   The result is signalled by done alone.
//
// Configuration macro: SEQ_ADDER_OVF_EN adds the ovf output.
//
// Debug: the FSM state is held in the signal "state" (type state_t) so that
//   checkers can bind to it hierarchically.
// ---------------------------------------------------------------------------
module seq_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // A 1-bit counter is still needed for WIDTH=1 so the "last" compare works.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             c;
  logic             c_next;
  logic             res_bit;
  logic [CW-1:0]    cnt;
  logic             last;

  // One full-adder slice on the current LSBs. The new result bit enters the
  // sum register at the MSB so that after WIDTH shifts bit 0 lands at bit 0.
  // Written as shift-then-overwrite so it stays legal for WIDTH=1.
  always_comb begin
    res_bit  = a_sh[0] ^ b_sh[0] ^ c;
    c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    sum_next = sum_sh >> 1;
    sum_next[WIDTH-1] = res_bit;
    last     = (cnt == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      carry  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            c      <= cin;
            sum_sh <= '0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          c      <= c_next;
          sum_sh <= sum_next;
          cnt    <= cnt + 1'b1;
          if (last) begin
            sum   <= sum_next;
            carry <= c_next;
`ifdef SEQ_ADDER_OVF_EN
            // On the MSB slice, c is the carry into the MSB and c_next the
            // carry out of it.
            ovf   <= c ^ c_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_adder
//   Bench for seq_adder. dut8 (WIDTH=8) is tracked every cycle against a
//   transaction-level model: a start accepted while idle queues a+b+cin and
//   the result must appear, with done, exactly WIDTH cycles later. dut1
//   (WIDTH=1) is checked against a literal full-adder truth table.
// ---------------------------------------------------------------------------
module tb_seq_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // dut8 signals
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, carry;
  logic [7:0] sum;
`ifdef SEQ_ADDER_OVF_EN
  logic       ovf;
`endif

  // dut1 signals
  logic       s1, c1;
  logic [0:0] a1, b1, sum1;
  logic       busy1, done1, carry1;
`ifdef SEQ_ADDER_OVF_EN
  logic       ovf1;
`endif

  seq_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
`ifdef SEQ_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  seq_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (s1),
    .a     (a1),
    .b     (b1),
    .cin   (c1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .carry (carry1)
`ifdef SEQ_ADDER_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result packed as {ovf, carry, sum}.
  function automatic logic [9:0] model_add(input logic [7:0] x, input logic [7:0] y,
                                           input logic ci);
    int u, sx, sy, s;
    logic o;
    u  = int'(x) + int'(y) + int'(ci);
    sx = $signed(x);
    sy = $signed(y);
    s  = sx + sy + int'(ci);
    o  = (s > 127) || (s < -128);
    return {o, u[8:0]};
  endfunction

  logic [9:0] exp_q[$];
  int         m_left = 0;
  logic       m_done = 1'b0;
  logic [7:0] m_sum  = 8'h00;
  logic       m_carry = 1'b0;
  logic       m_ovf  = 1'b0;

  // Transaction model of dut8, advanced on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_left  = 0;
      m_done  = 1'b0;
      m_sum   = 8'h00;
      m_carry = 1'b0;
      m_ovf   = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_ovf, m_carry, m_sum} = exp_q.pop_front();
          m_done = 1'b1;
        end
      end else if (start) begin
        exp_q.push_back(model_add(a, b, cin));
        m_left = 8;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",  busy,  (m_left > 0));
      chk("done",  done,  m_done);
      chk("sum",   sum,   m_sum);
      chk("carry", carry, m_carry);
`ifdef SEQ_ADDER_OVF_EN
      chk("ovf",   ovf,   m_ovf);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for done, counting negedges from the first cycle after the start
  // edge. A stray start pulse is thrown in while busy; it must be ignored.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (n == 3) start = 1'b1;
      if (n == 4) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic do_add(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic [7:0] es, input logic ec,
                        input logic eo);
    int n;
    @(posedge clk); #1;
    a = x; b = y; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom_range(0, 1));
    wait_done(n);
    chk({name, "_latency"}, n, 9);
    chk({name, "_sum"}, sum, es);
    chk({name, "_carry"}, carry, ec);
`ifdef SEQ_ADDER_OVF_EN
    chk({name, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("note: ovf expectation undefined for %s", name);
`endif
  endtask

  // Full-adder truth table indexed by {a, b, cin}, entries {carry, sum}.
  logic [1:0] fa_tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int pulses;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    s1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_sum",   sum,   8'h00);
    chk("reset_busy",  busy,  1'b0);
    chk("reset_done",  done,  1'b0);
    chk("reset_carry", carry, 1'b0);

    do_add("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    do_add("add_ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_add("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_add("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_add("add_00_00", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

    // Back-to-back: second start issued in the done cycle.
    @(posedge clk); #1;
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'hA5; b = 8'h5A;
    wait_done(n);
    chk("b2b_first_latency", n, 9);
    chk("b2b_first_sum", sum, 8'h03);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'hEE; b = 8'h77; cin = 1'b1;
    wait_done(n);
    chk("b2b_second_latency", n, 9);
    chk("b2b_second_sum", sum, 8'h30);
    chk("b2b_second_carry", carry, 1'b0);

    // Reset on the 4th SHIFT cycle aborts the addition.
    @(posedge clk); #1;
    a = 8'h55; b = 8'h22; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;          // SHIFT cycle 1
    start = 1'b0;
    @(posedge clk); #1;          // SHIFT cycle 2
    @(posedge clk); #1;          // SHIFT cycle 3
    @(posedge clk); #1;          // SHIFT cycle 4
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy",  busy,  1'b0);
    chk("rst_done",  done,  1'b0);
    chk("rst_sum",   sum,   8'h00);
    chk("rst_carry", carry, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("rst_no_done", pulses, 0);

    // WIDTH=1 full-adder truth table, done two cycles after start.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      @(posedge clk); #1;
      a1 = v[2]; b1 = v[1]; c1 = v[0]; s1 = 1'b1;
      @(posedge clk); #1;
      s1 = 1'b0;
      chk($sformatf("w1_busy_%0d", i), busy1, 1'b1);
      chk($sformatf("w1_early_done_%0d", i), done1, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("w1_done_%0d", i), done1, 1'b1);
      chk($sformatf("w1_result_%0d", i), {carry1, sum1}, fa_tt[i]);
    end
    @(posedge clk); #1;
    chk("w1_idle_busy", busy1, 1'b0);
    chk("w1_idle_done", done1, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
